rom_loader: RTL

Upstream feeder for the SDRAM controller's port1 request interface. Takes the MiST data_io byte stream during ROM download and packs byte pairs into 16-bit words. Buffers the words in a small FIFO and issues them as SDRAM writes using the toggle req/ack handshake. Back-pressures data_io through `ioctl_wait`, so a download never outruns the 7-cycle SDRAM slot.

---
 rtl/rom_loader_if.sv | 31 +++
 rtl/rom_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader_if.sv
// rom_loader_if: data_io byte stream plus SDRAM port1 write-request bus seen by rom_loader.
// The slave modport is the loader's view; master is the view of whatever drives it.
interface rom_loader_if;
    logic        ioctl_downl;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_we;
    logic [22:0] sdram_a;
    logic [1:0]  sdram_ds;
    logic [15:0] sdram_d;
    logic        busy;
    logic        overflow;
    logic [15:0] word_count;

    modport slave (
        input  ioctl_downl, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdram_ack,
        output ioctl_wait, sdram_req, sdram_we, sdram_a, sdram_ds, sdram_d,
        output busy, overflow, word_count
    );

    modport master (
        output ioctl_downl, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdram_ack,
        input  ioctl_wait, sdram_req, sdram_we, sdram_a, sdram_ds, sdram_d,
        input  busy, overflow, word_count
    );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: packs data_io ROM bytes into big-endian 16-bit words, queues them and writes them to SDRAM.
// Optional macro ROM_LOADER_FLUSH_EN writes orphan even bytes as {byte, 8'h00} instead of dropping them.
module rom_loader #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter logic [22:0] BASE_ADDR  = 23'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    rom_loader_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 23 + 2 + 16;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_CNT = CW'(FIFO_DEPTH - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [EW-1:0] w_head;

    logic          r_req;
    logic [22:0]   r_a;
    logic [1:0]    r_ds;
    logic [15:0]   r_d;
    logic          r_wait;
    logic          r_busy;
    logic          r_ovf;
    logic [15:0]   r_wcount;
    logic          r_downl_q;
    logic          r_hold_v;
    logic [7:0]    r_hold_d;
    logic [23:0]   r_hold_a;
    logic          r_fp;

    logic          w_accept;
    logic          w_rise;
    logic          w_hold_v_eff;
    logic [23:0]   w_addr_sum;
    logic [22:0]   w_word_a;
    logic          w_push_req;
    logic [EW-1:0] w_push_data;
    logic          w_can_push;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_load;
    logic          w_hold_load;
    logic          w_hold_clr;
    logic          w_flush_done;
    logic          w_flush_set;
    logic          w_fp_nxt;

    assign w_accept     = bus.ioctl_wr & bus.ioctl_downl & (bus.ioctl_index == ROM_INDEX);
    assign w_rise       = bus.ioctl_downl & ~r_downl_q;
    assign w_hold_v_eff = r_hold_v & ~w_rise;
    // Full 24-bit sum kept for the pairing compare; the SDRAM only sees the low 23 bits.
    assign w_addr_sum   = bus.ioctl_addr[24:1] + {1'b0, BASE_ADDR};
    assign w_word_a     = w_addr_sum[22:0];
    assign w_head       = r_mem[r_rd_ptr];
    assign w_can_push   = (r_count != FULL_CNT) | w_pop;
    assign w_push       = w_push_req & w_can_push;
    assign w_drop       = w_push_req & ~w_can_push;

`ifdef ROM_LOADER_FLUSH_EN
    assign w_flush_set = ~bus.ioctl_downl & r_downl_q & r_hold_v;
`else
    assign w_flush_set = 1'b0;
`endif

    always_comb begin
        w_push_req   = 1'b0;
        w_push_data  = '0;
        w_hold_load  = 1'b0;
        w_hold_clr   = 1'b0;
        w_flush_done = 1'b0;
        if (w_accept && !bus.ioctl_addr[0]) begin
            w_hold_load = 1'b1;
`ifdef ROM_LOADER_FLUSH_EN
            if (w_hold_v_eff) begin
                w_push_req  = 1'b1;
                w_push_data = {r_hold_a[22:0], 2'b10, r_hold_d, 8'h00};
            end
`endif
        end else if (w_accept) begin
            if (w_hold_v_eff && (r_hold_a == w_addr_sum)) begin
                w_push_req  = 1'b1;
                w_push_data = {w_word_a, 2'b11, r_hold_d, bus.ioctl_dout};
                w_hold_clr  = 1'b1;
            end else begin
                w_push_req  = 1'b1;
                w_push_data = {w_word_a, 2'b01, 8'h00, bus.ioctl_dout};
            end
        end else if (r_fp && w_can_push) begin
            // Falling-edge flush only goes out when a slot is free, so it is never dropped.
            w_push_req   = 1'b1;
            w_push_data  = {r_hold_a[22:0], 2'b10, r_hold_d, 8'h00};
            w_flush_done = 1'b1;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_comb begin
        w_fp_nxt = r_fp;
        if (w_rise) begin
            w_fp_nxt = 1'b0;
        end else if (w_flush_set) begin
            w_fp_nxt = 1'b1;
        end else if (w_flush_done) begin
            w_fp_nxt = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.sdram_ack == r_req) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Reset aligns req to ack so the controller never sees a stale toggle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_req <= bus.sdram_ack;
            r_a   <= '0;
            r_ds  <= '0;
            r_d   <= '0;
        end else if (w_load) begin
            r_req <= ~r_req;
            r_a   <= w_head[40:18];
            r_ds  <= w_head[17:16];
            r_d   <= w_head[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_downl_q <= 1'b0;
            r_hold_v  <= 1'b0;
            r_fp      <= 1'b0;
            r_ovf     <= 1'b0;
            r_wcount  <= '0;
            r_wait    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_downl_q <= bus.ioctl_downl;
            if (w_hold_load) begin
                r_hold_v <= 1'b1;
            end else if (w_rise || w_hold_clr || w_flush_done) begin
                r_hold_v <= 1'b0;
            end
            r_fp  <= w_fp_nxt;
            r_ovf <= (r_ovf & ~w_rise) | w_drop;
            if (w_rise) begin
                r_wcount <= {15'd0, w_pop};
            end else if (w_pop) begin
                r_wcount <= r_wcount + 1'b1;
            end
            r_wait <= (w_count_nxt >= WAIT_CNT);
            r_busy <= bus.ioctl_downl | (w_count_nxt != '0) | (w_state_nxt == S_WAIT) | w_fp_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hold_load) begin
            r_hold_d <= bus.ioctl_dout;
            r_hold_a <= w_addr_sum;
        end
    end

    assign bus.ioctl_wait = r_wait;
    assign bus.sdram_req  = r_req;
    assign bus.sdram_we   = 1'b1;
    assign bus.sdram_a    = r_a;
    assign bus.sdram_ds   = r_ds;
    assign bus.sdram_d    = r_d;
    assign bus.busy       = r_busy;
    assign bus.overflow   = r_ovf;
    assign bus.word_count = r_wcount;
endmodule
